dlx_alu_issue: RTL

Execute-stage issue controller that sits in front of the DLX ALU and acts as its initiator. It accepts one decoded-register-read instruction at a time over a valid/ready handshake and decodes the DLX R-type or I-type arithmetic/logic word into the ALU opcode and operands. It strobes the ALU, waits out the ALU's registered latency, then presents the captured result, carry and zero flags to writeback over a second valid/ready handshake.

---
 rtl/dlx_alu_issue_if.sv | 40 ++++
 rtl/dlx_alu_issue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dlx_alu_issue_if.sv
// Bundle of the instruction-in, ALU-side and writeback-side signals of the
// DLX execute-stage issue controller. The controller uses the master view;
// the surrounding pipeline/ALU/writeback use the slave view.
interface dlx_alu_issue_if;
  // instruction / operand offer
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        in_valid;
  logic        in_ready;
  // ALU initiator side
  logic [3:0]  alu_i;
  logic        alu_ex;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_res;
  logic        alu_carry;
  logic        alu_z;
  // writeback side
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        wb_carry;
  logic        wb_z;
  logic        err;

  modport master (
    input  instr, rs1_val, rs2_val, in_valid, alu_res, alu_carry, alu_z, wb_ready,
    output in_ready, alu_i, alu_ex, alu_op1, alu_op2,
           wb_valid, wb_rd, wb_we, wb_data, wb_carry, wb_z, err
  );

  modport slave (
    output instr, rs1_val, rs2_val, in_valid, alu_res, alu_carry, alu_z, wb_ready,
    input  in_ready, alu_i, alu_ex, alu_op1, alu_op2,
           wb_valid, wb_rd, wb_we, wb_data, wb_carry, wb_z, err
  );
endinterface

// File: rtl/dlx_alu_issue.sv
// DLX execute-stage issue controller: decodes one R/I-type ALU instruction,
// strobes the ALU, waits ALU_LAT edges, then holds the captured result for
// writeback. At most one instruction is in flight.
module dlx_alu_issue #(
  parameter int ALU_LAT = 1  // 1..4
) (
  input  logic           clk,
  input  logic           rst_n,
  dlx_alu_issue_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
  localparam logic [3:0] OP_SEQ = 4'd8,  OP_SNE = 4'd9,  OP_SLT = 4'd10, OP_SGT = 4'd11;
  localparam logic [3:0] OP_SLE = 4'd12, OP_SGE = 4'd13;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  alu_i_q, alu_i_d;
  logic [31:0] alu_op1_q, alu_op1_d;
  logic [31:0] alu_op2_q, alu_op2_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_carry_q, wb_carry_d;
  logic        wb_z_q, wb_z_d;
  logic        err_q, err_d;

  logic        dec_legal;
  logic [3:0]  dec_op;
  logic [31:0] dec_op1, dec_op2;
  logic [4:0]  dec_rd;
  logic [5:0]  opc, func;
  logic [15:0] imm;

  // Decode the offered word into ALU opcode, operands and destination.
  always_comb begin
    opc       = bus.instr[31:26];
    func      = bus.instr[5:0];
    imm       = bus.instr[15:0];
    dec_legal = 1'b1;
    dec_op    = OP_ADD;
    dec_op1   = bus.rs1_val;
    dec_op2   = {{16{imm[15]}}, imm};
    dec_rd    = bus.instr[20:16];
    if (opc == 6'h00) begin
      dec_op2 = bus.rs2_val;
      dec_rd  = bus.instr[15:11];
      case (func)
        6'h20, 6'h21: dec_op = OP_ADD;
        6'h22, 6'h23: dec_op = OP_SUB;
        6'h24:        dec_op = OP_AND;
        6'h25:        dec_op = OP_OR;
        6'h26:        dec_op = OP_XOR;
        6'h04:        dec_op = OP_SLL;
        6'h06:        dec_op = OP_SRL;
        6'h07:        dec_op = OP_SRA;
        6'h28:        dec_op = OP_SEQ;
        6'h29:        dec_op = OP_SNE;
        6'h2A:        dec_op = OP_SLT;
        6'h2B:        dec_op = OP_SGT;
        6'h2C:        dec_op = OP_SLE;
        6'h2D:        dec_op = OP_SGE;
        default:      dec_legal = 1'b0;
      endcase
    end else begin
      case (opc)
        // sign-extended immediate (default dec_op2)
        6'h08: dec_op = OP_ADD;
        6'h0A: dec_op = OP_SUB;
        6'h18: dec_op = OP_SEQ;
        6'h19: dec_op = OP_SNE;
        6'h1A: dec_op = OP_SLT;
        6'h1B: dec_op = OP_SGT;
        6'h1C: dec_op = OP_SLE;
        6'h1D: dec_op = OP_SGE;
        // zero-extended immediate
        6'h09: begin dec_op = OP_ADD; dec_op2 = {16'h0, imm}; end
        6'h0B: begin dec_op = OP_SUB; dec_op2 = {16'h0, imm}; end
        6'h0C: begin dec_op = OP_AND; dec_op2 = {16'h0, imm}; end
        6'h0D: begin dec_op = OP_OR;  dec_op2 = {16'h0, imm}; end
        6'h0E: begin dec_op = OP_XOR; dec_op2 = {16'h0, imm}; end
        // shift amount from the low five immediate bits
        6'h14: begin dec_op = OP_SLL; dec_op2 = {27'h0, imm[4:0]}; end
        6'h16: begin dec_op = OP_SRL; dec_op2 = {27'h0, imm[4:0]}; end
        6'h17: begin dec_op = OP_SRA; dec_op2 = {27'h0, imm[4:0]}; end
        // LHI is an ADD of zero and the immediate placed in the upper half
        6'h0F: begin dec_op = OP_ADD; dec_op1 = 32'h0; dec_op2 = {imm, 16'h0}; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Next-state: IDLE -> ISSUE -> WAIT (ALU_LAT edges) -> WB -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_i_d    = alu_i_q;
    alu_op1_d  = alu_op1_q;
    alu_op2_d  = alu_op2_q;
    rd_d       = rd_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    wb_carry_d = wb_carry_q;
    wb_z_d     = wb_z_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (dec_legal) begin
            alu_i_d   = dec_op;
            alu_op1_d = dec_op1;
            alu_op2_d = dec_op2;
            rd_d      = dec_rd;
            state_d   = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 3'(ALU_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          wb_rd_d    = rd_q;
          wb_we_d    = (rd_q != 5'd0);
          wb_data_d  = bus.alu_res;
          wb_carry_d = bus.alu_carry;
          wb_z_d     = bus.alu_z;
          state_d    = S_WB;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin  // S_WB
        if (bus.wb_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      alu_i_q    <= 4'd0;
      alu_op1_q  <= 32'd0;
      alu_op2_q  <= 32'd0;
      rd_q       <= 5'd0;
      wb_rd_q    <= 5'd0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_carry_q <= 1'b0;
      wb_z_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_i_q    <= alu_i_d;
      alu_op1_q  <= alu_op1_d;
      alu_op2_q  <= alu_op2_d;
      rd_q       <= rd_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      wb_carry_q <= wb_carry_d;
      wb_z_q     <= wb_z_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.alu_ex   = (state_q == S_ISSUE);
  assign bus.alu_i    = alu_i_q;
  assign bus.alu_op1  = alu_op1_q;
  assign bus.alu_op2  = alu_op2_q;
  assign bus.wb_valid = (state_q == S_WB);
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_carry = wb_carry_q;
  assign bus.wb_z     = wb_z_q;
  assign bus.err      = err_q;

endmodule
